frv_asi_dispatch: RTL and testbench
===================================

# frv_asi_dispatch

Issue-side controller for the algorithm-specific instruction unit. It accepts one ASI operation from the decode stage and holds its operands while driving the ASI unit's valid/uop/rs1/rs2/shamt interface. It waits for the unit's ready, captures the result and presents it to writeback through a valid/ready handshake. It also sequences AES state flushes on pipeline flush, and runs a watchdog that turns a hung multi-cycle AES operation into an error completion.

## Interface
- `TIMEOUT`, default 15: max BUSY cycles without `asi_ready` before error completion; 0 disables the watchdog.
- `g_clk` in 1: global clock.
- `g_resetn` in 1: asynchronous active-low reset.
- `s_valid` in 1: decode presents an ASI op.
- `s_ready` out 1: dispatcher can accept.
- `s_uop` in OP+1: operation code.
- `s_rs1`, `s_rs2` in XLEN: source operands.
- `s_shamt` in 2: SHA3 shift amount.
- `s_rd` in 5: destination register.
- `flush` in 1: pipeline flush; kill any held op.
- `flush_data` in 32: data forwarded to the AES submodules on flush.
- `asi_valid` out 1: op presented to the ASI unit.
- `asi_uop`, `asi_rs1`, `asi_rs2`, `asi_shamt` out (widths as `s_*`): registered operands.
- `asi_ready` in 1: ASI unit completes this cycle.
- `asi_result` in XLEN: result, valid with `asi_ready`.
- `asi_flush_aessub`, `asi_flush_aesmix` out 1: one-cycle AES state flush pulses.
- `asi_flush_data` out 32: flush payload.
- `w_valid` out 1: result available to writeback.
- `w_ready` in 1: writeback accepts.
- `w_rd` out 5: destination register.
- `w_result` out XLEN: captured result.
- `w_err` out 1: op terminated by the watchdog.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - `s_ready`=1.
  - On `s_valid & s_ready`: latch uop/rs1/rs2/shamt/rd and go to BUSY.
- **BUSY:**
  - `asi_valid`=1 and `asi_*` driven from the latched registers.
  - The watchdog counter increments each BUSY cycle.
  - On `asi_ready`: capture `asi_result` into `w_result`, set `w_err`=0, go to DONE.
  - Otherwise, if `TIMEOUT`≠0 and the counter reaches `TIMEOUT`:
    - `w_result`=0, `w_err`=1, go to DONE.
    - Schedule an AES flush with payload 0.
  - If `asi_ready` and the timeout occur in the same cycle, `asi_ready` wins.
- **DONE:**
  - `w_valid`=1 and `w_rd`/`w_result`/`w_err` are held stable.
  - On `w_ready`: go to IDLE.
  - `s_ready`=`w_ready` in DONE. Simultaneous `w_ready & s_valid` latches the new op and goes directly to BUSY.
- **Operand gating:**
  - Outside BUSY, `asi_uop`/`asi_rs1`/`asi_rs2`/`asi_shamt` are all 0 and `asi_valid`=0.
  - The held operands never leak to the ASI unit outside BUSY.
- **Flush:**
  - Has priority over every other event in any state. `s_ready` is forced to 0 in the flush cycle and nothing is accepted.
  - Next state is IDLE and the counter clears.
  - `w_valid` falls and a pending DONE result is discarded.
- **AES flush outputs:**
  - Registered. `asi_flush_aessub` and `asi_flush_aesmix` are both 1 for exactly the one cycle after a cycle with `flush`=1 or a watchdog expiry.
  - `asi_flush_data` that cycle = `flush_data` sampled with `flush`, or 0 for a watchdog expiry. It is 0 at all other times.
  - If `flush` and the watchdog expiry occur together, the `flush` payload is used.
- **Counter:**
  - Width is clog2(`TIMEOUT`+1), saturating.
  - Cleared on entering BUSY and on flush.
- **Reset:**
  - State IDLE, so `s_ready`=1.
  - All other outputs 0 and all registers 0.
  - Reset assertion mid-BUSY drops `asi_valid` immediately (asynchronous) and produces no flush pulse.

## Timing
- Accept at cycle edge N. `asi_valid`=1 from cycle N+1.
- A single-cycle ASI op (SHA2/SHA3/fast AES) returns `asi_ready` in N+1, so `w_valid`=1 in N+2.
- A k-cycle op gives `w_valid` at N+1+k.
- Steady-state throughput with `w_ready` tied high and single-cycle ops: one op per 2 cycles (BUSY, DONE-with-accept).
- Watchdog with `TIMEOUT`=T:
  - T BUSY cycles without ready gives DONE with `w_err` on the next cycle.
  - The flush pulse occurs in the first DONE cycle.
- `s_ready`, `asi_valid` and `w_valid` are decoded from state registers only. `s_ready` additionally depends on `w_ready`/`flush`.

## Structure
- Shared package (alongside the existing ASI uop encodings, OP, XL, XLEN) gets:
  - the `asi_disp_state_t` enum (IDLE/BUSY/DONE);
  - the default watchdog constant `ASI_DISP_TIMEOUT`=15.
- Flat module; the watchdog counter is inline and no sub-module is warranted.
- The bench instantiates the ASI unit behind it, plus a stub unit with programmable ready latency.

## Test plan
- **SHA256 op:** uop `ASI_SHA256_S0`, rs1=0x0000_0001, stub ready in 1 cycle.
  - `w_valid` at N+2 with the stub's result.
  - `w_rd` echoes 5'd7.
  - `w_err`=0.
- **Slow AES:** stub ready after 4 cycles with result 0xDEAD_BEEF.
  - `asi_valid` high for exactly 4 cycles with stable operands.
  - `w_valid` at N+5.
  - Operands read 0 after the stub asserts ready.
- **Backpressure and back-to-back:** `w_ready`=0 for 3 cycles in DONE.
  - `w_*` held and `s_ready`=0.
  - Raising `w_ready` with `s_valid`=1 accepts the second op in the same cycle, with BUSY next.
- **Flush mid-BUSY:** `flush` with `flush_data`=0x1234_5678.
  - Next cycle: IDLE, `asi_valid`=0, both `asi_flush_*`=1, `asi_flush_data`=0x1234_5678.
  - No `w_valid`.
- **Watchdog:** `TIMEOUT`=15, stub never ready.
  - After 15 BUSY cycles: DONE with `w_err`=1 and `w_result`=0.
  - One-cycle flush pulse with data 0.
  - Ready arriving on cycle 15 instead gives a normal completion.
- **Reset mid-BUSY:** assert `g_resetn`=0 mid-cycle.
  - `asi_valid`, `w_valid` and the flush pulses drop immediately; `s_ready`=1.
  - After release, a new op completes normally.

Source files
------------

// File: rtl/frv_asi_dispatch_pkg.sv
// Shared ASI definitions: operand widths, uop encodings and dispatcher state/watchdog constants.
package frv_asi_dispatch_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned XL   = XLEN - 1;
    localparam int unsigned OP   = 5;

    localparam logic [OP:0] ASI_AESSUB_ENC    = 6'h00;
    localparam logic [OP:0] ASI_AESSUB_ENCROT = 6'h01;
    localparam logic [OP:0] ASI_AESSUB_DEC    = 6'h02;
    localparam logic [OP:0] ASI_AESMIX_ENC    = 6'h04;
    localparam logic [OP:0] ASI_AESMIX_DEC    = 6'h05;
    localparam logic [OP:0] ASI_SHA256_S0     = 6'h10;
    localparam logic [OP:0] ASI_SHA256_S1     = 6'h11;
    localparam logic [OP:0] ASI_SHA256_S2     = 6'h12;
    localparam logic [OP:0] ASI_SHA256_S3     = 6'h13;
    localparam logic [OP:0] ASI_SHA3_XY       = 6'h20;
    localparam logic [OP:0] ASI_SHA3_X1       = 6'h21;

    localparam int unsigned ASI_DISP_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ASI_DISP_IDLE = 2'd0,
        ASI_DISP_BUSY = 2'd1,
        ASI_DISP_DONE = 2'd2
    } asi_disp_state_t;

endpackage

// File: rtl/frv_asi_dispatch.sv
// Issue-side ASI controller: holds one op for the ASI unit, returns its result to
// writeback, sequences AES flushes and converts a hung op into an error completion.
module frv_asi_dispatch
    import frv_asi_dispatch_pkg::*;
#(
    parameter int unsigned TIMEOUT = ASI_DISP_TIMEOUT
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [OP:0] s_uop,
    input  logic [XL:0] s_rs1,
    input  logic [XL:0] s_rs2,
    input  logic [1:0]  s_shamt,
    input  logic [4:0]  s_rd,
    input  logic        flush,
    input  logic [31:0] flush_data,
    output logic        asi_valid,
    output logic [OP:0] asi_uop,
    output logic [XL:0] asi_rs1,
    output logic [XL:0] asi_rs2,
    output logic [1:0]  asi_shamt,
    input  logic        asi_ready,
    input  logic [XL:0] asi_result,
    output logic        asi_flush_aessub,
    output logic        asi_flush_aesmix,
    output logic [31:0] asi_flush_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [4:0]  w_rd,
    output logic [XL:0] w_result,
    output logic        w_err
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX  = (TIMEOUT == 0) ? '1 : CW'(TIMEOUT);

    asi_disp_state_t state, state_nxt;

    logic [OP:0]   uop_q;
    logic [XL:0]   rs1_q;
    logic [XL:0]   rs2_q;
    logic [1:0]    shamt_q;
    logic [4:0]    rd_q;
    logic [XL:0]   result_q;
    logic          err_q;
    logic [CW-1:0] wd_cnt;
    logic          fl_pulse;
    logic [31:0]   fl_data;
    logic          busy;
    logic          accept;
    logic          wd_expire;

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        busy      = 1'b0;
        w_valid   = 1'b0;
        case (state)
            ASI_DISP_IDLE: s_ready = !flush;
            ASI_DISP_BUSY: busy = 1'b1;
            ASI_DISP_DONE: begin
                w_valid = 1'b1;
                s_ready = w_ready && !flush;
            end
            default: ;
        endcase

        accept = s_valid && s_ready;
        // expiry fires in the TIMEOUT-th BUSY cycle; a ready in that same cycle wins
        wd_expire = busy && !asi_ready && (TIMEOUT != 0) && (wd_cnt == WD_LAST);

        case (state)
            ASI_DISP_IDLE: if (accept) state_nxt = ASI_DISP_BUSY;
            ASI_DISP_BUSY: if (asi_ready || wd_expire) state_nxt = ASI_DISP_DONE;
            ASI_DISP_DONE: if (w_ready) state_nxt = accept ? ASI_DISP_BUSY : ASI_DISP_IDLE;
            default:       state_nxt = ASI_DISP_IDLE;
        endcase

        if (flush) state_nxt = ASI_DISP_IDLE;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state    <= ASI_DISP_IDLE;
            uop_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            shamt_q  <= '0;
            rd_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_cnt   <= '0;
            fl_pulse <= 1'b0;
            fl_data  <= '0;
        end else begin
            state    <= state_nxt;
            fl_pulse <= flush || wd_expire;
            fl_data  <= flush ? flush_data : '0;

            if (flush) begin
                wd_cnt <= '0;
            end else if (accept) begin
                uop_q   <= s_uop;
                rs1_q   <= s_rs1;
                rs2_q   <= s_rs2;
                shamt_q <= s_shamt;
                rd_q    <= s_rd;
                wd_cnt  <= '0;
            end else if (busy) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if (asi_ready) begin
                    result_q <= asi_result;
                    err_q    <= 1'b0;
                end else if (wd_expire) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end
        end
    end

    // held operands are only visible to the ASI unit while BUSY
    assign asi_valid = busy;
    assign asi_uop   = busy ? uop_q   : '0;
    assign asi_rs1   = busy ? rs1_q   : '0;
    assign asi_rs2   = busy ? rs2_q   : '0;
    assign asi_shamt = busy ? shamt_q : '0;

    assign asi_flush_aessub = fl_pulse;
    assign asi_flush_aesmix = fl_pulse;
    assign asi_flush_data   = fl_data;

    assign w_rd     = rd_q;
    assign w_result = result_q;
    assign w_err    = err_q;

endmodule

// File: tb/tb_frv_asi_dispatch.sv
// Bench for frv_asi_dispatch: stub ASI unit with programmable ready latency,
// table-driven ops with a writeback scoreboard, plus flush/backpressure/reset sequences.
module tb_frv_asi_dispatch;
    import frv_asi_dispatch_pkg::*;

    localparam int unsigned T = 15;

    logic        g_clk;
    logic        g_resetn;
    logic        s_valid;
    logic        s_ready;
    logic [OP:0] s_uop;
    logic [XL:0] s_rs1;
    logic [XL:0] s_rs2;
    logic [1:0]  s_shamt;
    logic [4:0]  s_rd;
    logic        flush;
    logic [31:0] flush_data;
    logic        asi_valid;
    logic [OP:0] asi_uop;
    logic [XL:0] asi_rs1;
    logic [XL:0] asi_rs2;
    logic [1:0]  asi_shamt;
    logic        asi_ready;
    logic [XL:0] asi_result;
    logic        asi_flush_aessub;
    logic        asi_flush_aesmix;
    logic [31:0] asi_flush_data;
    logic        w_valid;
    logic        w_ready;
    logic [4:0]  w_rd;
    logic [XL:0] w_result;
    logic        w_err;

    frv_asi_dispatch #(.TIMEOUT(T)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_uop(s_uop), .s_rs1(s_rs1),
        .s_rs2(s_rs2), .s_shamt(s_shamt), .s_rd(s_rd),
        .flush(flush), .flush_data(flush_data),
        .asi_valid(asi_valid), .asi_uop(asi_uop), .asi_rs1(asi_rs1),
        .asi_rs2(asi_rs2), .asi_shamt(asi_shamt), .asi_ready(asi_ready),
        .asi_result(asi_result), .asi_flush_aessub(asi_flush_aessub),
        .asi_flush_aesmix(asi_flush_aesmix), .asi_flush_data(asi_flush_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_rd(w_rd),
        .w_result(w_result), .w_err(w_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Stub ASI unit: ready in the stub_lat-th valid cycle (0 = never), result from stub_fn.
    int unsigned stub_lat;
    logic        fix_en;
    logic [31:0] fix_val;
    int unsigned stub_cnt;

    function automatic logic [31:0] stub_fn(input logic [OP:0] u, input logic [31:0] a,
                                            input logic [31:0] b, input logic [1:0] sh);
        return (a ^ {b[23:0], b[31:24]}) + 32'(u) + (32'(sh) * 32'h0101_0101);
    endfunction

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) stub_cnt <= 0;
        else           stub_cnt <= (asi_valid && !asi_ready) ? stub_cnt + 1 : 0;
    end

    assign asi_ready  = asi_valid && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
    assign asi_result = fix_en ? fix_val : stub_fn(asi_uop, asi_rs1, asi_rs2, asi_shamt);

    int n_pass;
    int n_chk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always @(negedge g_clk) begin
        if (g_resetn && w_valid && w_ready) begin
            if (sb.size() == 0) begin
                check("wb_spurious", 64'(w_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wb_result", 64'({w_err, w_rd, w_result}), 64'({e.err, e.rd, e.res}));
            end
        end
    end

    typedef struct {
        logic [OP:0] uop;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  sh;
        logic [4:0]  rd;
        int unsigned lat;
        logic        fix;
        logic [31:0] fixv;
        int unsigned exp_lat;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [OP:0] uop, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [1:0] sh,
                                input logic [4:0] rd, input int unsigned lat,
                                input logic fix, input logic [31:0] fixv);
        vec_t v;
        v.uop = uop; v.rs1 = rs1; v.rs2 = rs2; v.sh = sh; v.rd = rd;
        v.lat = lat; v.fix = fix; v.fixv = fixv;
        if (lat == 0) begin
            v.exp_lat = T + 1;
            v.exp_res = '0;
            v.exp_err = 1'b1;
        end else begin
            v.exp_lat = lat + 1;
            v.exp_res = fix ? fixv : stub_fn(uop, rs1, rs2, sh);
            v.exp_err = 1'b0;
        end
        return v;
    endfunction

    task automatic drive_op(input logic [OP:0] uop, input logic [31:0] rs1,
                            input logic [31:0] rs2, input logic [1:0] sh, input logic [4:0] rd);
        s_valid = 1'b1; s_uop = uop; s_rs1 = rs1; s_rs2 = rs2; s_shamt = sh; s_rd = rd;
    endtask

    task automatic clear_op();
        s_valid = 1'b0; s_uop = '0; s_rs1 = '0; s_rs2 = '0; s_shamt = '0; s_rd = '0;
    endtask

    vec_t        tbl[6];
    vec_t        v;
    int unsigned cyc;
    int unsigned nvalid;
    int unsigned nwv;
    logic        stable;
    logic        got;
    logic [31:0] exp_a;

    initial begin
        n_pass = 0;
        n_chk  = 0;
        tbl[0] = mk(ASI_SHA256_S0,  32'h0000_0001, 32'h0000_0000, 2'd0, 5'd7,  1,  1'b0, '0);
        tbl[1] = mk(ASI_AESSUB_ENC, 32'h0011_2233, 32'h4455_6677, 2'd0, 5'd3,  4,  1'b1, 32'hDEAD_BEEF);
        tbl[2] = mk(ASI_SHA3_XY,    32'h8000_0003, 32'hF0F0_1234, 2'd3, 5'd31, 2,  1'b0, '0);
        tbl[3] = mk(ASI_AESMIX_ENC, 32'h0BAD_F00D, 32'h1111_2222, 2'd1, 5'd9,  0,  1'b0, '0);
        tbl[4] = mk(ASI_AESMIX_DEC, 32'h7777_0000, 32'h0000_8888, 2'd2, 5'd12, T,  1'b0, '0);
        tbl[5] = mk(ASI_SHA256_S3,  32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 5'd1,  14, 1'b0, '0);

        g_resetn = 1'b1; flush = 1'b0; flush_data = '0; w_ready = 1'b1;
        stub_lat = 1; fix_en = 1'b0; fix_val = '0;
        clear_op();
        #2 g_resetn = 1'b0;

        @(negedge g_clk);
        @(negedge g_clk);
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_outputs", 64'({asi_valid, w_valid, w_err, asi_flush_aessub, asi_flush_aesmix}), 64'(0));
        check("rst_data", 64'({w_result, asi_flush_data}), 64'(0));
        @(posedge g_clk); #1;
        g_resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            @(posedge g_clk); #1;
            stub_lat = v.lat; fix_en = v.fix; fix_val = v.fixv;
            drive_op(v.uop, v.rs1, v.rs2, v.sh, v.rd);
            @(posedge g_clk); #1;
            clear_op();
            sb.push_back('{v.rd, v.exp_res, v.exp_err});
            cyc = 0; nvalid = 0; stable = 1'b1; got = 1'b0;
            while (!got && cyc < 40) begin
                @(negedge g_clk);
                cyc++;
                if (asi_valid) begin
                    nvalid++;
                    if (asi_uop !== v.uop || asi_rs1 !== v.rs1 || asi_rs2 !== v.rs2 || asi_shamt !== v.sh)
                        stable = 1'b0;
                end
                if (w_valid) got = 1'b1;
            end
            check("vec_latency", 64'(cyc), 64'(v.exp_lat));
            check("vec_asi_valid_cycles", 64'(nvalid), 64'(v.exp_lat - 1));
            check("vec_operands_stable", 64'(stable), 64'(1));
            check("vec_operand_gating",
                  64'(asi_valid | (|asi_uop) | (|asi_rs1) | (|asi_rs2) | (|asi_shamt)), 64'(0));
            check("vec_flush_pulse_done", 64'({asi_flush_aessub, asi_flush_aesmix}), 64'({2{v.exp_err}}));
            check("vec_flush_data_done", 64'(asi_flush_data), 64'(0));
            @(negedge g_clk);
            check("vec_flush_pulse_after", 64'({asi_flush_aessub, asi_flush_aesmix, asi_flush_data}), 64'(0));
        end

        // Backpressure in DONE, then accept the next op in the same cycle w_ready rises.
        w_ready = 1'b0; stub_lat = 1; fix_en = 1'b0;
        exp_a = stub_fn(ASI_SHA256_S1, 32'hA5A5_0F0F, 32'h0000_0000, 2'd1);
        @(posedge g_clk); #1;
        drive_op(ASI_SHA256_S1, 32'hA5A5_0F0F, 32'h0000_0000, 2'd1, 5'd5);
        @(posedge g_clk); #1;
        clear_op();
        sb.push_back('{5'd5, exp_a, 1'b0});
        cyc = 0;
        while (!w_valid && cyc < 10) begin
            @(negedge g_clk);
            cyc++;
        end
        check("bp_latency", 64'(cyc), 64'(2));
        @(posedge g_clk); #1;
        drive_op(ASI_SHA256_S2, 32'h1357_9BDF, 32'h2468_ACE0, 2'd0, 5'd20);
        for (int k = 0; k < 3; k++) begin
            @(negedge g_clk);
            check("bp_hold", 64'({w_valid, s_ready, w_err, w_rd, w_result}), 64'({1'b1, 1'b0, 1'b0, 5'd5, exp_a}));
        end
        @(posedge g_clk); #1;
        w_ready = 1'b1;
        @(negedge g_clk);
        check("bp_s_ready_follows_w_ready", 64'(s_ready), 64'(1));
        @(posedge g_clk); #1;
        clear_op();
        sb.push_back('{5'd20, stub_fn(ASI_SHA256_S2, 32'h1357_9BDF, 32'h2468_ACE0, 2'd0), 1'b0});
        @(negedge g_clk);
        check("b2b_busy_next", 64'({asi_valid, w_valid, asi_rs1}), 64'({1'b1, 1'b0, 32'h1357_9BDF}));
        cyc = 0;
        while (!w_valid && cyc < 10) begin
            @(negedge g_clk);
            cyc++;
        end
        check("b2b_latency", 64'(cyc), 64'(1));

        // Flush in the second BUSY cycle of a 4-cycle op.
        @(posedge g_clk); #1;
        stub_lat = 4;
        drive_op(ASI_AESSUB_DEC, 32'h0F0F_F0F0, 32'h5555_AAAA, 2'd0, 5'd11);
        @(posedge g_clk); #1;
        clear_op();
        @(posedge g_clk); #1;
        flush = 1'b1; flush_data = 32'h1234_5678;
        drive_op(ASI_SHA256_S0, 32'h0000_0042, 32'h0, 2'd0, 5'd2);
        @(negedge g_clk);
        check("flush_s_ready", 64'(s_ready), 64'(0));
        @(posedge g_clk); #1;
        flush = 1'b0; flush_data = '0;
        clear_op();
        @(negedge g_clk);
        check("flush_idle_pulse", 64'({asi_valid, s_ready, asi_flush_aessub, asi_flush_aesmix}), 64'(4'b0111));
        check("flush_data", 64'(asi_flush_data), 64'(32'h1234_5678));
        @(negedge g_clk);
        check("flush_pulse_one_cycle", 64'({asi_flush_aessub, asi_flush_aesmix, asi_flush_data}), 64'(0));
        nwv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge g_clk);
            if (w_valid || asi_valid) nwv++;
        end
        check("flush_no_completion", 64'(nwv), 64'(0));

        // Asynchronous reset mid-BUSY.
        @(posedge g_clk); #1;
        stub_lat = 0;
        drive_op(ASI_AESMIX_ENC, 32'hCAFE_BABE, 32'h0000_0001, 2'd0, 5'd13);
        @(posedge g_clk); #1;
        clear_op();
        @(posedge g_clk);
        @(posedge g_clk); #3;
        g_resetn = 1'b0;
        #1;
        check("rst_mid_busy", 64'({asi_valid, w_valid, s_ready, asi_flush_aessub}), 64'(4'b0010));
        @(negedge g_clk);
        g_resetn = 1'b1;

        // Asynchronous reset during a flush pulse.
        @(posedge g_clk); #1;
        flush = 1'b1; flush_data = 32'hCAFE_0001;
        @(posedge g_clk); #1;
        flush = 1'b0; flush_data = '0;
        check("pulse_before_rst", 64'({asi_flush_aessub, asi_flush_data}), 64'({1'b1, 32'hCAFE_0001}));
        #2 g_resetn = 1'b0;
        #1;
        check("rst_kills_pulse", 64'({asi_flush_aessub, asi_flush_aesmix, asi_flush_data}), 64'(0));
        @(negedge g_clk);
        g_resetn = 1'b1;
        @(negedge g_clk);
        check("no_pulse_after_rst", 64'({asi_flush_aessub, asi_flush_aesmix}), 64'(0));

        // Normal op after reset release.
        @(posedge g_clk); #1;
        stub_lat = 1;
        drive_op(ASI_SHA3_X1, 32'h0102_0304, 32'h0506_0708, 2'd2, 5'd17);
        @(posedge g_clk); #1;
        clear_op();
        sb.push_back('{5'd17, stub_fn(ASI_SHA3_X1, 32'h0102_0304, 32'h0506_0708, 2'd2), 1'b0});
        cyc = 0;
        while (!w_valid && cyc < 10) begin
            @(negedge g_clk);
            cyc++;
        end
        check("post_rst_latency", 64'(cyc), 64'(2));

        repeat (3) @(negedge g_clk);
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
